// File: rtl/dense_layer_pkg.sv
// dense_layer_pkg: shared FSM state, size derivations and leaky activation for dense_layer_mac
package dense_layer_pkg;
  typedef enum logic [1:0] {IDLE, MAC, WRITE, HOLD} state_e;
  localparam int MAX_W = 128;
  function automatic int acc_w(input int data_w, input int weight_w, input int in_size);
    return data_w + weight_w + $clog2(in_size);
  endfunction
  function automatic int passes(input int out_size, input int lanes);
    return out_size / lanes;
  endfunction
  // Callers sign-extend into MAX_W and truncate back; negative values shift toward -inf
  function automatic logic signed [MAX_W-1:0] leaky_act(input logic signed [MAX_W-1:0] v,
                                                        input logic en, input int shift);
    return (en && v < 0) ? v >>> shift : v;
  endfunction
endpackage

// File: rtl/dense_mac_lane.sv
// dense_mac_lane: one signed multiply-accumulate lane with synchronous clear
// clk_i/rst_ni clock and async active-low reset; clear_i zeroes the accumulator (wins over en_i);
// en_i adds weight_i*data_i; acc_o is the ACC_W-bit running sum.
module dense_mac_lane #(
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 45
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       en_i,
  input  logic signed [WEIGHT_W-1:0] weight_i,
  input  logic signed [DATA_W-1:0]   data_i,
  output logic signed [ACC_W-1:0]    acc_o
);
  logic signed [ACC_W-1:0] acc_q, acc_d, prod;
  assign prod  = ACC_W'(weight_i) * ACC_W'(data_i);
  assign acc_d = clear_i ? '0 : en_i ? acc_q + prod : acc_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc_o = acc_q;
endmodule

// File: rtl/dense_layer_mac.sv
// dense_layer_mac: handshaked y = act(W*x) engine with LANES parallel MAC lanes over OUT_SIZE/LANES passes
// in_valid_i/in_ready_o/in_data_i/leaky_en_i accept one input vector (leaky_en_i sampled with it);
// out_valid_o/out_ready_i/out_data_o present the result vector, held stable until accepted.
// WEIGHTS is the flattened row-major ROM, W[o][i] at [(o*IN_SIZE+i)*WEIGHT_W +: WEIGHT_W].
module dense_layer_mac import dense_layer_pkg::*; #(
  parameter int IN_SIZE     = 20,
  parameter int OUT_SIZE    = 10,
  parameter int LANES       = 5,
  parameter int DATA_W      = 32,
  parameter int WEIGHT_W    = 8,
  parameter int LEAKY_SHIFT = 3,
  parameter logic [OUT_SIZE*IN_SIZE*WEIGHT_W-1:0] WEIGHTS = '0,
  localparam int ACC_W      = acc_w(DATA_W, WEIGHT_W, IN_SIZE),
  localparam int PASSES     = passes(OUT_SIZE, LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [IN_SIZE*DATA_W-1:0]   in_data_i,
  input  logic                        leaky_en_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [OUT_SIZE*ACC_W-1:0]   out_data_o
);
  localparam int IDX_W  = $clog2(IN_SIZE);
  localparam int PASS_W = PASSES > 1 ? $clog2(PASSES) : 1;
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic leaky_q, clear, en, capture, last_idx;
  logic [IN_SIZE*DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] x_el [IN_SIZE];
  assign capture     = state_q == IDLE && in_valid_i;
  assign last_idx    = idx_q == IDX_W'(IN_SIZE - 1);
  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = state_q == HOLD;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    clear   = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: if (in_valid_i) begin
        state_d = MAC;
        idx_d   = '0;
        pass_d  = '0;
        clear   = 1'b1;
      end
      MAC: begin
        en      = 1'b1;
        idx_d   = last_idx ? '0 : idx_q + 1'b1;
        state_d = last_idx ? WRITE : MAC;
      end
      WRITE: begin
        clear = 1'b1;
        idx_d = '0;
        if (pass_q == PASS_W'(PASSES - 1)) state_d = HOLD;
        else begin
          pass_d  = pass_q + 1'b1;
          state_d = MAC;
        end
      end
      default: state_d = out_ready_i ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
      leaky_q <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      leaky_q <= capture ? leaky_en_i : leaky_q;
      x_q     <= capture ? in_data_i : x_q;
    end
  for (genvar i = 0; i < IN_SIZE; i++) begin : g_x
    assign x_el[i] = x_q[i*DATA_W +: DATA_W];
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Per-lane slice of the ROM: the rows this lane visits, indexed by pass then input element
    logic signed [WEIGHT_W-1:0] rom [PASSES][IN_SIZE];
    logic signed [ACC_W-1:0] acc, act;
    logic signed [ACC_W-1:0] out_q [PASSES];
    for (genvar p = 0; p < PASSES; p++) begin : g_p
      for (genvar i = 0; i < IN_SIZE; i++) begin : g_i
        assign rom[p][i] = WEIGHTS[((p*LANES + l)*IN_SIZE + i)*WEIGHT_W +: WEIGHT_W];
      end
      assign out_data_o[(p*LANES + l)*ACC_W +: ACC_W] = out_q[p];
    end
    dense_mac_lane #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear),
      .en_i     (en),
      .weight_i (rom[pass_q][idx_q]),
      .data_i   (x_el[idx_q]),
      .acc_o    (acc)
    );
    assign act = ACC_W'(leaky_act(MAX_W'(acc), leaky_q, LEAKY_SHIFT));
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) for (int p = 0; p < PASSES; p++) out_q[p] <= '0;
      else if (state_q == WRITE) out_q[pass_q] <= act;
  end
endmodule
